// File: rtl/shifter_seq_if.sv
// Handshake/data bundle for shifter_seq.
// master: the requester driving start/op/shamt/d_in.
// slave : the shifter returning d_out/busy/done.
interface shifter_seq_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) ();
    logic               start;
    logic [2:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   d_in;
    logic [WIDTH-1:0]   d_out;
    logic               busy;
    logic               done;

    modport master (
        output start, op, shamt, d_in,
        input  d_out, busy, done
    );

    modport slave (
        input  start, op, shamt, d_in,
        output d_out, busy, done
    );
endinterface

// File: rtl/shifter_seq.sv
// Multi-cycle register shifter: LOAD/LSL/LSR/ASR (and ROL/ROR when
// SHIFTER_ROTATE_EN is defined), moving at most STEP bit positions per clock.
// Without SHIFTER_ROTATE_EN, ops 101/110 complete as NOP and no rotate logic
// is built.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; LOAD/NOP/zero-amount ops complete here
// S_SHIFT | stepping d_out by min(rem, STEP) per clock until rem reaches 0
module shifter_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    shifter_seq_if.slave  io_bus
);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSL  = 3'b010;
    localparam logic [2:0] OP_LSR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
`ifdef SHIFTER_ROTATE_EN
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
`endif

    localparam logic [SHAMT_W-1:0] STEP_C   = SHAMT_W'(STEP);
    localparam logic [SHAMT_W-1:0] SHAMT_MAX = SHAMT_W'(WIDTH - 1);

    state_t             r_state;
    logic [2:0]         r_op;
    logic [SHAMT_W-1:0] r_rem;
    logic [WIDTH-1:0]   r_d_out;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [2:0]         w_op_nxt;
    logic [SHAMT_W-1:0] w_rem_nxt;
    logic [WIDTH-1:0]   w_d_out_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic [SHAMT_W-1:0] w_shamt_sat;
    logic [SHAMT_W-1:0] w_step;
    logic [SHAMT_W-1:0] w_rem_left;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_is_shift;

    // Amounts beyond WIDTH-1 only exist when WIDTH is not a power of two.
    generate
        if ((1 << SHAMT_W) > WIDTH) begin : g_sat
            assign w_shamt_sat = (io_bus.shamt > SHAMT_MAX) ? SHAMT_MAX : io_bus.shamt;
        end else begin : g_nosat
            assign w_shamt_sat = io_bus.shamt;
        end
    endgenerate

    assign w_step     = (r_rem < STEP_C) ? r_rem : STEP_C;
    assign w_rem_left = r_rem - w_step;

    // Decode whether the requested op is a multi-cycle shift.
    always_comb begin
        w_is_shift = 1'b0;
        case (io_bus.op)
            OP_LSL, OP_LSR, OP_ASR: w_is_shift = 1'b1;
`ifdef SHIFTER_ROTATE_EN
            OP_ROL, OP_ROR:         w_is_shift = 1'b1;
`endif
            default:                w_is_shift = 1'b0;
        endcase
    end

    // One step of the latched op applied to the current result.
    always_comb begin
        w_shifted = r_d_out;
        case (r_op)
            OP_LSL: w_shifted = r_d_out << w_step;
            OP_LSR: w_shifted = r_d_out >> w_step;
            OP_ASR: w_shifted = $signed(r_d_out) >>> w_step;
`ifdef SHIFTER_ROTATE_EN
            OP_ROL: w_shifted = (r_d_out << w_step) | (r_d_out >> (WIDTH - int'(w_step)));
            OP_ROR: w_shifted = (r_d_out >> w_step) | (r_d_out << (WIDTH - int'(w_step)));
`endif
            default: w_shifted = r_d_out;
        endcase
    end

    // Next-state and next-output logic; done is a single-cycle pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_rem_nxt   = r_rem;
        w_d_out_nxt = r_d_out;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    if (io_bus.op == OP_LOAD) begin
                        w_d_out_nxt = io_bus.d_in;
                        w_done_nxt  = 1'b1;
                    end else if (w_is_shift && (w_shamt_sat != '0)) begin
                        w_op_nxt    = io_bus.op;
                        w_rem_nxt   = w_shamt_sat;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                w_d_out_nxt = w_shifted;
                w_rem_nxt   = w_rem_left;
                if (w_rem_left == '0) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any shift in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_rem   <= '0;
            r_d_out <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_rem   <= w_rem_nxt;
            r_d_out <= w_d_out_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign io_bus.d_out = r_d_out;
    assign io_bus.busy  = r_busy;
    assign io_bus.done  = r_done;

endmodule

// File: tb/tb_shifter_seq.sv
// Scoreboard bench for shifter_seq (WIDTH=8, STEP=2). Each start pushes the
// per-cycle trace expected from a bit-serial model; a negedge monitor pops
// and compares whenever busy or done is high.
module tb_shifter_seq;

    localparam int W    = 8;
    localparam int SW   = 3;
    localparam int STEP = 2;
`ifdef SHIFTER_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    shifter_seq_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

    shifter_seq #(.WIDTH(W), .SHAMT_W(SW), .STEP(STEP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (bus)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [W-1:0] m_dout;
    int           n_chk  = 0;
    int           n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] step1(input logic [2:0] op, input logic [W-1:0] v);
        case (op)
            3'b010:  return {v[W-2:0], 1'b0};
            3'b011:  return {1'b0, v[W-1:1]};
            3'b100:  return {v[W-1], v[W-1:1]};
            3'b101:  return {v[W-2:0], v[W-1]};
            3'b110:  return {v[0], v[W-1:1]};
            default: return v;
        endcase
    endfunction

    function automatic bit is_shift(input logic [2:0] op);
        case (op)
            3'b010, 3'b011, 3'b100: return 1'b1;
            3'b101, 3'b110:         return ROT_EN;
            default:                return 1'b0;
        endcase
    endfunction

    // Drive one start cycle (caller sits just after a negedge) and push the trace.
    task automatic launch(input logic [2:0] op, input int amt, input logic [W-1:0] d);
        int r;
        int s;
        bus.start = 1'b1;
        bus.op    = op;
        bus.shamt = SW'(amt);
        bus.d_in  = d;
        if (op == 3'b001) begin
            sb.push_back('{d: d, busy: 1'b0, done: 1'b1});
            m_dout = d;
        end else if (is_shift(op) && amt != 0) begin
            sb.push_back('{d: m_dout, busy: 1'b1, done: 1'b0});
            r = (amt > W - 1) ? W - 1 : amt;
            while (r > 0) begin
                s = (r < STEP) ? r : STEP;
                repeat (s) m_dout = step1(op, m_dout);
                r -= s;
                sb.push_back('{d: m_dout, busy: (r != 0), done: (r == 0)});
            end
        end else begin
            sb.push_back('{d: m_dout, busy: 1'b0, done: 1'b1});
        end
        @(negedge clk); #1;
        bus.start = 1'b0;
        bus.d_in  = W'($urandom);
        bus.op    = 3'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (bus.done !== 1'b1 && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        if (bus.done !== 1'b1) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic idle(input string tag);
        @(negedge clk); #1;
        check({tag, "_done_low"}, bus.done, 1'b0);
    endtask

    // Compare every cycle in which the DUT signals activity.
    always @(negedge clk) begin
        if (reset_n && (bus.busy === 1'b1 || bus.done === 1'b1)) begin
            if (sb.size() == 0) begin
                check("spurious_busy_done", {bus.busy, bus.done}, 2'b00);
            end else begin
                mon_e = sb.pop_front();
                check("d_out", bus.d_out, mon_e.d);
                check("busy", bus.busy, mon_e.busy);
                check("done", bus.done, mon_e.done);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   rop;
        int           ramt;
        logic [W-1:0] rd;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.shamt = '0;
        bus.d_in  = '0;
        m_dout    = '0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_d_out", bus.d_out, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk); #1;

        launch(3'b001, 0, 8'hA5); wait_done("load");   idle("load");
        launch(3'b010, 5, 8'h00); wait_done("lsl5");   idle("lsl5");

        launch(3'b001, 0, 8'h80); wait_done("load80");
        launch(3'b100, 7, 8'h00);
        bus.start = 1'b1; bus.op = 3'b001; bus.d_in = 8'h3C;
        @(negedge clk); #1;
        bus.start = 1'b0;
        wait_done("asr7");
        launch(3'b001, 0, 8'h3C); wait_done("b2b_load"); idle("b2b_load");

        launch(3'b001, 0, 8'h80); wait_done("load80b");
        launch(3'b011, 7, 8'h00); wait_done("lsr7");   idle("lsr7");

        launch(3'b001, 0, 8'h81); wait_done("load81");
        launch(3'b110, 3, 8'h00); wait_done("ror3");   idle("ror3");
        launch(3'b101, 6, 8'h00); wait_done("rol6");   idle("rol6");

        launch(3'b111, 4, 8'hFF); wait_done("rsvd");
        launch(3'b000, 2, 8'hFF); wait_done("nop");
        launch(3'b010, 0, 8'hFF); wait_done("lsl0");   idle("lsl0");

        launch(3'b001, 0, 8'hA5); wait_done("load_r"); idle("load_r");
        launch(3'b010, 5, 8'h00);
        reset_n = 1'b0;
        #1;
        check("midrst_d_out", bus.d_out, 8'h00);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        sb.delete();
        m_dout = '0;
        @(negedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("postrst_busy", bus.busy, 1'b0);
        check("postrst_d_out", bus.d_out, 8'h00);

        repeat (30) begin
            rop  = 3'($urandom_range(0, 7));
            ramt = $urandom_range(0, 7);
            rd   = W'($urandom);
            launch(rop, ramt, rd);
            wait_done("rand");
            if ($urandom_range(0, 1) == 1) idle("rand");
        end

        repeat (3) @(negedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        check("final_busy", bus.busy, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
